// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse tracker: status bit positions,
// FSM state encoding and default screen geometry.
package mouse_pkg;

  localparam int LEFT   = 0;
  localparam int RIGHT  = 1;
  localparam int MIDDLE = 2;
  localparam int SYNC   = 3;
  localparam int XSIGN  = 4;
  localparam int YSIGN  = 5;
  localparam int XOVF   = 6;
  localparam int YOVF   = 7;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    APPLY,
    PULSE
  } state_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: signed 12-bit position plus signed delta, saturated
// to [0, MAX] so the cursor never wraps off a screen edge.
module mouse_axis_clamp #(
  parameter int W   = 10,
  parameter int MAX = 639
) (
  input  logic signed [11:0] pos,
  input  logic signed [11:0] delta,
  output logic [W-1:0]       result
);

  localparam logic signed [11:0] MAX_S = 12'(MAX);

  logic signed [11:0] sum;

  always_comb begin
    sum = pos + delta;
    if (sum[11])
      result = '0;
    else if (sum > MAX_S)
      result = W'(MAX);
    else
      result = sum[W-1:0];
  end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet tracker: turns receiver packets into a clamped cursor
// position and button levels. Define MOUSE_SYNC_CHECK_EN to drop packets without status[3].
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] record,
  input  logic        finished,
  output logic [9:0]  cursor_x,
  output logic [8:0]  cursor_y,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic        left_click,
  output logic        pkt_valid,
  output logic        pkt_drop
);

  state_t state;
  logic        fin_q;
  logic [23:0] pkt;
  logic        pkt_event;
  logic [7:0]  status;
  logic signed [8:0]  dx, dy;
  logic signed [11:0] x_pos, y_pos, x_delta, y_delta;
  logic [9:0]  x_new;
  logic [8:0]  y_new;
  logic        unused_bits;

  assign pkt_event   = finished & ~fin_q;
  assign status      = pkt[23:16];
  assign unused_bits = ^{record[31:24], status[SYNC]};

  // Overflow replaces the delta with the extreme value of its sign.
  always_comb begin
    dx = {status[XSIGN], pkt[15:8]};
    dy = {status[YSIGN], pkt[7:0]};
    if (status[XOVF]) dx = status[XSIGN] ? 9'sh100 : 9'sh0FF;
    if (status[YOVF]) dy = status[YSIGN] ? 9'sh100 : 9'sh0FF;
  end

  // PS/2 Y is positive upward while row 0 is the top, so Y moves by -dy.
  assign x_pos   = {2'b00, cursor_x};
  assign y_pos   = {3'b000, cursor_y};
  assign x_delta = {{3{dx[8]}}, dx};
  assign y_delta = -{{3{dy[8]}}, dy};

  mouse_axis_clamp #(.W(10), .MAX(SCREEN_W - 1)) u_clamp_x (
    .pos    (x_pos),
    .delta  (x_delta),
    .result (x_new)
  );

  mouse_axis_clamp #(.W(9), .MAX(SCREEN_H - 1)) u_clamp_y (
    .pos    (y_pos),
    .delta  (y_delta),
    .result (y_new)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fin_q      <= 1'b0;
      pkt        <= '0;
      cursor_x   <= 10'(SCREEN_W / 2);
      cursor_y   <= 9'(SCREEN_H / 2);
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      left_click <= 1'b0;
      pkt_valid  <= 1'b0;
      pkt_drop   <= 1'b0;
    end else begin
      fin_q      <= finished;
      left_click <= 1'b0;
      pkt_valid  <= 1'b0;
      pkt_drop   <= pkt_event && (state != IDLE);
      case (state)
        IDLE: begin
          if (pkt_event) begin
            pkt   <= record[23:0];
            state <= LATCH;
          end
        end
        LATCH: begin
`ifdef MOUSE_SYNC_CHECK_EN
          if (!status[SYNC]) begin
            pkt_drop <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= APPLY;
          end
`else
          state <= APPLY;
`endif
        end
        APPLY: begin
          cursor_x   <= x_new;
          cursor_y   <= y_new;
          btn_left   <= status[LEFT];
          btn_right  <= status[RIGHT];
          btn_middle <= status[MIDDLE];
          left_click <= status[LEFT] & ~btn_left;
          pkt_valid  <= 1'b1;
          state      <= PULSE;
        end
        PULSE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed scoreboard bench for mouse_tracker: a reference model queues the
// expected cursor/button state per packet, checked when pkt_valid pulses.
module tb_mouse_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] record;
  logic        finished;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;
  logic        btn_left, btn_right, btn_middle;
  logic        left_click, pkt_valid, pkt_drop;

  typedef struct {
    int x;
    int y;
    int btns;
    int click;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int valid_count = 0;
  int drop_count = 0;
  int pushed = 0;

  int m_x, m_y, m_l, m_r, m_m;

  mouse_tracker #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk        (clk),
    .reset      (reset),
    .record     (record),
    .finished   (finished),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .left_click (left_click),
    .pkt_valid  (pkt_valid),
    .pkt_drop   (pkt_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pkt_drop === 1'b1) drop_count++;
    if (pkt_valid === 1'b1) begin
      exp_t e;
      valid_count++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("cursor_x", 32'(cursor_x), 32'(e.x));
        check("cursor_y", 32'(cursor_y), 32'(e.y));
        check("buttons", 32'({btn_middle, btn_right, btn_left}), 32'(e.btns));
        check("left_click", 32'(left_click), 32'(e.click));
      end
    end
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model; returns 1 if the packet is expected to be applied.
  function automatic bit model_apply(input logic [31:0] rec);
    logic [7:0] st;
    int dxv, dyv;
    exp_t e;
    st = rec[23:16];
`ifdef MOUSE_SYNC_CHECK_EN
    if (!st[3]) return 1'b0;
`endif
    dxv = st[4] ? int'(rec[15:8]) - 256 : int'(rec[15:8]);
    dyv = st[5] ? int'(rec[7:0]) - 256 : int'(rec[7:0]);
    if (st[6]) dxv = st[4] ? -256 : 255;
    if (st[7]) dyv = st[5] ? -256 : 255;
    m_x = clampi(m_x + dxv, 639);
    m_y = clampi(m_y - dyv, 479);
    e.click = (st[0] && m_l == 0) ? 1 : 0;
    m_l = int'(st[0]);
    m_r = int'(st[1]);
    m_m = int'(st[2]);
    e.x = m_x;
    e.y = m_y;
    e.btns = m_m * 4 + m_r * 2 + m_l;
    sb.push_back(e);
    pushed++;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_l = 0; m_r = 0; m_m = 0;
  endtask

  task automatic send(input logic [31:0] rec);
    bit applied;
    applied = model_apply(rec);
    @(negedge clk);
    record   = rec;
    finished = 1'b1;
    repeat (5) @(negedge clk);
    finished = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    bit applied;
    int v0, d0;
    reset = 1'b1;
    record = '0;
    finished = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x", 32'(cursor_x), 32'd320);
    check("rst_y", 32'(cursor_y), 32'd240);
    check("rst_outs", 32'({btn_left, btn_right, btn_middle, left_click, pkt_valid, pkt_drop}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First packet with latency probe: pulse exactly on the third cycle.
    applied = model_apply(32'h0008_1005);
    record = 32'h0008_1005;
    finished = 1'b1;
    @(negedge clk); check("lat_c1", 32'(pkt_valid), 32'd0);
    @(negedge clk); check("lat_c2", 32'(pkt_valid), 32'd0);
    @(negedge clk); check("lat_c3", 32'(pkt_valid), 32'd1);
    @(negedge clk); check("lat_c4", 32'(pkt_valid), 32'd0);
    finished = 1'b0;
    repeat (2) @(negedge clk);

    // Overflow and clamping on both axes.
    send(32'h0048_0000);
    send(32'h0048_0000);
    send(32'h0058_0000);
    send(32'h0088_0000);
    send(32'h00A8_0000);
    send(32'h0058_0000);
    send(32'h0018_8600);
    check("x_at_5", 32'(cursor_x), 32'd5);
    send(32'h0018_F000);
    check("x_no_wrap", 32'(cursor_x), 32'd0);

    // Buttons and left-click edge.
    send(32'h0009_0000);
    send(32'h0009_0000);
    check("btn_left_held", 32'(btn_left), 32'd1);
    send(32'h0008_0000);
    send(32'h000F_0000);

    // Level held high yields a single event.
    #1 v0 = valid_count;
    applied = model_apply(32'h0008_0100);
    @(negedge clk);
    record = 32'h0008_0100;
    finished = 1'b1;
    repeat (100) @(negedge clk);
    finished = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("held_one_valid", 32'(valid_count - v0), 32'd1);

    // Second rise while busy is dropped and does not disturb the first.
    #1 d0 = drop_count;
    applied = model_apply(32'h0008_0200);
    @(negedge clk);
    record = 32'h0008_0200;
    finished = 1'b1;
    @(negedge clk); finished = 1'b0;
    @(negedge clk); record = 32'h0048_0000; finished = 1'b1;
    repeat (4) @(negedge clk);
    finished = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("busy_drop", 32'(drop_count - d0), 32'd1);

    // Packet without the sync bit.
    #1 d0 = drop_count; v0 = valid_count;
    send(32'h0001_0000);
`ifdef MOUSE_SYNC_CHECK_EN
    #1 check("sync_drop", 32'(drop_count - d0), 32'd1);
    check("sync_btn_left", 32'(btn_left), 32'(m_l));
`else
    #1 check("nosync_applied", 32'(valid_count - v0), 32'd1);
    check("nosync_btn_left", 32'(btn_left), 32'd1);
`endif
    check("sync_x", 32'(cursor_x), 32'(m_x));

    // Reset while in APPLY: immediate return home, packet lost.
    #1 v0 = valid_count;
    @(negedge clk);
    record = 32'h0048_0000;
    finished = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_apply_x", 32'(cursor_x), 32'd320);
    check("rst_apply_y", 32'(cursor_y), 32'd240);
    check("rst_apply_btn", 32'(btn_left), 32'd0);
    finished = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("rst_apply_no_valid", 32'(valid_count - v0), 32'd0);

    // First rise after reset is a normal event.
    send(32'h0008_1005);
    check("post_rst_x", 32'(cursor_x), 32'd336);
    check("post_rst_y", 32'(cursor_y), 32'd235);

    repeat (4) @(negedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    check("valid_total", 32'(valid_count), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
